// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS Harvard core front end.
package mips_pkg;

   typedef enum logic [1:0] {
      RK_NONE     = 2'd0,
      RK_BRANCH   = 2'd1,
      RK_JUMP     = 2'd2,
      RK_JUMP_REG = 2'd3
   } redirect_kind_t;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DELAY  = 2'd1,
      ST_HALTED = 2'd2
   } pc_state_t;

   localparam logic [31:0] RESET_VECTOR_C = 32'hBFC00000;
   localparam logic [31:0] HALT_ADDR_C    = 32'h00000000;

endpackage

// File: rtl/mips_target_calc.sv
// Combinational redirect target and misalignment check for the
// instruction at p_i.
module mips_target_calc
   import mips_pkg::*;
(
   input  logic [31:0] p_i,
   input  logic [1:0]  kind_i,
   input  logic [15:0] offset16_i,
   input  logic [25:0] index26_i,
   input  logic [31:0] reg_target_i,
   output logic [31:0] target_o,
   output logic        misaligned_o
);

   logic [31:0] seq;
   logic [31:0] br_off;

   assign seq    = p_i + 32'd4;
   assign br_off = {{14{offset16_i[15]}}, offset16_i, 2'b00};

   always_comb begin
      target_o     = seq;
      misaligned_o = 1'b0;
      case (redirect_kind_t'(kind_i))
         RK_BRANCH:   target_o = seq + br_off;
         RK_JUMP:     target_o = {seq[31:28], index26_i, 2'b00};
         RK_JUMP_REG: begin
            target_o     = reg_target_i;
            misaligned_o = |reg_target_i[1:0];
         end
         default:     target_o = seq;
      endcase
   end

endmodule

// File: rtl/mips_pc_unit.sv
// Program counter sequencer with branch delay slot, halt-on-zero
// convention and sticky misaligned jump-register fault.
module mips_pc_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_C,
   parameter logic [31:0] HALT_ADDR    = HALT_ADDR_C
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable,
   input  logic [1:0]  redirect_kind,
   input  logic [15:0] offset16,
   input  logic [25:0] index26,
   input  logic [31:0] reg_target,
   output logic [31:0] pc,
   output logic [31:0] link_addr,
   output logic        in_delay_slot,
   output logic        active,
   output logic        fault
);

   pc_state_t   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pending_q, pending_d;
   logic        bad_q, bad_d;
   logic        fault_q, fault_d;
   logic [31:0] target;
   logic        misaligned;

   mips_target_calc u_calc (
      .p_i          (pc_q),
      .kind_i       (redirect_kind),
      .offset16_i   (offset16),
      .index26_i    (index26),
      .reg_target_i (reg_target),
      .target_o     (target),
      .misaligned_o (misaligned)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_RUN;
         pc_q      <= RESET_VECTOR;
         pending_q <= 32'd0;
         bad_q     <= 1'b0;
         fault_q   <= 1'b0;
      end else if (clk_enable) begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pending_q <= pending_d;
         bad_q     <= bad_d;
         fault_q   <= fault_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pending_d = pending_q;
      bad_d     = bad_q;
      fault_d   = fault_q;
      case (state_q)
         ST_RUN: begin
            pc_d = pc_q + 32'd4;
            if (redirect_kind_t'(redirect_kind) != RK_NONE) begin
               pending_d = target;
               bad_d     = misaligned;
               fault_d   = fault_q | misaligned;
               state_d   = ST_DELAY;
            end
         end
         ST_DELAY: begin
            // A misaligned target is never fetched; pc stays on the slot.
            if (bad_q) begin
               state_d = ST_HALTED;
            end else begin
               pc_d    = pending_q;
               state_d = (pending_q == HALT_ADDR) ? ST_HALTED : ST_RUN;
            end
         end
         default: state_d = ST_HALTED;
      endcase
   end

   assign pc            = pc_q;
   assign link_addr     = pc_q + 32'd8;
   assign in_delay_slot = (state_q == ST_DELAY);
   assign active        = (state_q != ST_HALTED);
   assign fault         = fault_q;

endmodule

// File: tb/tb_mips_pc_unit.sv
// Directed-vector bench for mips_pc_unit.
module tb_mips_pc_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_enable;
   logic [1:0]  redirect_kind;
   logic [15:0] offset16;
   logic [25:0] index26;
   logic [31:0] reg_target;
   logic [31:0] pc;
   logic [31:0] link_addr;
   logic        in_delay_slot;
   logic        active;
   logic        fault;

   int vectors = 0;
   int miscompares = 0;

   mips_pc_unit dut (
      .clk           (clk),
      .reset         (reset),
      .clk_enable    (clk_enable),
      .redirect_kind (redirect_kind),
      .offset16      (offset16),
      .index26       (index26),
      .reg_target    (reg_target),
      .pc            (pc),
      .link_addr     (link_addr),
      .in_delay_slot (in_delay_slot),
      .active        (active),
      .fault         (fault)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [1:0] k, input logic [15:0] o,
                      input logic [25:0] ix, input logic [31:0] r);
      redirect_kind = k;
      offset16      = o;
      index26       = ix;
      reg_target    = r;
   endtask

   task automatic do_reset(input int advance);
      @(negedge clk);
      reset = 1'b0;
      clk_enable = 1'b1;
      req(2'd0, 16'h0, 26'h0, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < advance; i++) tick();
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b0;
      clk_enable = 1'b1;
      req(2'd0, 16'h0, 26'h0, 32'h0);
      #1;
      vectors++;
      if (pc !== 32'hBFC00000) begin miscompares++; $display("FAIL rst_pc got %h exp BFC00000", pc); end
      vectors++;
      if (link_addr !== 32'hBFC00008) begin miscompares++; $display("FAIL rst_link got %h exp BFC00008", link_addr); end
      vectors++;
      if ({in_delay_slot, active, fault} !== 3'b010) begin miscompares++; $display("FAIL rst_flags got %b exp 010", {in_delay_slot, active, fault}); end
      @(negedge clk);
      reset = 1'b1;
      tick();
      vectors++;
      if (pc !== 32'hBFC00004) begin miscompares++; $display("FAIL none1 got %h exp BFC00004", pc); end
      tick();
      vectors++;
      if (pc !== 32'hBFC00008 || active !== 1'b1) begin miscompares++; $display("FAIL none2 got %h/%b exp BFC00008/1", pc, active); end
   endtask

   task automatic test_jump();
      do_reset(1);
      req(2'd2, 16'h0, 26'h2, 32'h0);
      vectors++;
      if (link_addr !== 32'hBFC0000C) begin miscompares++; $display("FAIL jmp_link got %h exp BFC0000C", link_addr); end
      tick();
      req(2'd0, 16'h0, 26'h0, 32'h0);
      vectors++;
      if (pc !== 32'hBFC00008 || in_delay_slot !== 1'b1) begin miscompares++; $display("FAIL jmp_slot got %h/%b exp BFC00008/1", pc, in_delay_slot); end
      tick();
      vectors++;
      if (pc !== 32'hB0000008 || in_delay_slot !== 1'b0) begin miscompares++; $display("FAIL jmp_tgt got %h/%b exp B0000008/0", pc, in_delay_slot); end
   endtask

   task automatic test_branch();
      do_reset(4);
      req(2'd1, 16'hFFFF, 26'h0, 32'h0);
      tick();
      vectors++;
      if (pc !== 32'hBFC00014 || in_delay_slot !== 1'b1) begin miscompares++; $display("FAIL br_slot got %h exp BFC00014", pc); end
      req(2'd2, 16'h0, 26'h123, 32'h0);
      tick();
      req(2'd0, 16'h0, 26'h0, 32'h0);
      vectors++;
      if (pc !== 32'hBFC00010 || in_delay_slot !== 1'b0) begin miscompares++; $display("FAIL br_tgt got %h exp BFC00010", pc); end
      req(2'd1, 16'h0000, 26'h0, 32'h0);
      tick();
      req(2'd0, 16'h0, 26'h0, 32'h0);
      tick();
      vectors++;
      if (pc !== 32'hBFC00014 || in_delay_slot !== 1'b0) begin miscompares++; $display("FAIL br_self got %h exp BFC00014", pc); end
   endtask

   task automatic test_halt();
      do_reset(8);
      req(2'd3, 16'h0, 26'h0, 32'h0);
      tick();
      req(2'd0, 16'h0, 26'h0, 32'h0);
      vectors++;
      if (pc !== 32'hBFC00024 || in_delay_slot !== 1'b1) begin miscompares++; $display("FAIL halt_slot got %h exp BFC00024", pc); end
      tick();
      vectors++;
      if (pc !== 32'h0 || active !== 1'b0) begin miscompares++; $display("FAIL halt_enter got %h/%b exp 00000000/0", pc, active); end
      for (int i = 0; i < 5; i++) begin
         req(2'd2, 16'h0, 26'h3, 32'h0);
         tick();
         vectors++;
         if (pc !== 32'h0 || active !== 1'b0) begin miscompares++; $display("FAIL halt_hold%0d got %h/%b exp 00000000/0", i, pc, active); end
      end
   endtask

   task automatic test_misaligned();
      do_reset(1);
      req(2'd3, 16'h0, 26'h0, 32'hBFC00102);
      tick();
      req(2'd0, 16'h0, 26'h0, 32'h0);
      vectors++;
      if (pc !== 32'hBFC00008 || fault !== 1'b1 || active !== 1'b1) begin miscompares++; $display("FAIL mis_slot got %h/f%b/a%b exp BFC00008/1/1", pc, fault, active); end
      tick();
      vectors++;
      if (pc !== 32'hBFC00008 || active !== 1'b0) begin miscompares++; $display("FAIL mis_halt got %h/%b exp BFC00008/0", pc, active); end
      tick(); tick();
      vectors++;
      if (pc !== 32'hBFC00008 || fault !== 1'b1) begin miscompares++; $display("FAIL mis_sticky got %h/%b exp BFC00008/1", pc, fault); end
      do_reset(0);
      vectors++;
      if (fault !== 1'b0 || active !== 1'b1) begin miscompares++; $display("FAIL mis_clear got f%b a%b exp 0/1", fault, active); end
   endtask

   task automatic test_enable_reset();
      do_reset(1);
      req(2'd2, 16'h0, 26'h2, 32'h0);
      tick();
      clk_enable = 1'b0;
      req(2'd1, 16'h0010, 26'h0, 32'h0);
      for (int i = 0; i < 3; i++) tick();
      vectors++;
      if (pc !== 32'hBFC00008 || in_delay_slot !== 1'b1) begin miscompares++; $display("FAIL en_hold got %h/%b exp BFC00008/1", pc, in_delay_slot); end
      reset = 1'b0;
      #1;
      vectors++;
      if (pc !== 32'hBFC00000 || in_delay_slot !== 1'b0 || active !== 1'b1) begin miscompares++; $display("FAIL async_rst got %h/%b exp BFC00000/0", pc, in_delay_slot); end
      @(negedge clk);
      reset = 1'b1;
      clk_enable = 1'b1;
      req(2'd0, 16'h0, 26'h0, 32'h0);
      tick();
      vectors++;
      if (pc !== 32'hBFC00004 || in_delay_slot !== 1'b0) begin miscompares++; $display("FAIL rst_discard got %h exp BFC00004", pc); end
   endtask

   task automatic test_wrap();
      do_reset(0);
      req(2'd3, 16'h0, 26'h0, 32'hFFFFFFFC);
      tick();
      req(2'd0, 16'h0, 26'h0, 32'h0);
      tick();
      vectors++;
      if (pc !== 32'hFFFFFFFC || link_addr !== 32'h00000004) begin miscompares++; $display("FAIL wrap_tgt got %h/%h exp FFFFFFFC/00000004", pc, link_addr); end
      tick();
      vectors++;
      if (pc !== 32'h0 || active !== 1'b1) begin miscompares++; $display("FAIL wrap_seq got %h/%b exp 00000000/1", pc, active); end
   endtask

   initial begin
      reset = 1'b1;
      clk_enable = 1'b1;
      req(2'd0, 16'h0, 26'h0, 32'h0);
      test_reset();
      test_jump();
      test_branch();
      test_halt();
      test_misaligned();
      test_enable_reset();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
